demux_1_8: RTL and testbench



---
 rtl/demux_1_8_pkg.sv | 23 ++
 rtl/demux_1_8_dec.sv | 13 +
 rtl/demux_1_8.sv | 47 ++++
 tb/tb_demux_1_8.sv | 134 +++++++++++++
 4 files changed

// File: rtl/demux_1_8_pkg.sv
// Shared constants and the one-hot select decode for the 1-to-8 demultiplexer.
// Any select code that is not a clean binary value decodes to no lane at all.
package demux_1_8_pkg;

    localparam int SEL_W = 3;
    localparam int N_OUT = 2 ** SEL_W;

    // In simulation, an X/Z select falls through to the default and returns no lane.
    function automatic logic [N_OUT-1:0] onehot_dec(input logic [SEL_W-1:0] sel);
        case (sel)
            3'd0:    onehot_dec = 8'b0000_0001;
            3'd1:    onehot_dec = 8'b0000_0010;
            3'd2:    onehot_dec = 8'b0000_0100;
            3'd3:    onehot_dec = 8'b0000_1000;
            3'd4:    onehot_dec = 8'b0001_0000;
            3'd5:    onehot_dec = 8'b0010_0000;
            3'd6:    onehot_dec = 8'b0100_0000;
            3'd7:    onehot_dec = 8'b1000_0000;
            default: onehot_dec = '0;
        endcase
    endfunction

endpackage

// File: rtl/demux_1_8_dec.sv
// Purpose: SEL_W-to-N_OUT one-hot lane decoder.
// Latency: combinational, 0 cycles.
// Backpressure: none; it is a pure function of sel.
module demux_1_8_dec
    import demux_1_8_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    output logic [N_OUT-1:0] dec
);

    assign dec = onehot_dec(sel);

endmodule

// File: rtl/demux_1_8.sv
// Purpose: steer 'in' to output lane s; every other lane is zero. DEMUX_1_8_COMB_OUT_EN selects a combinational output.
// Latency: 1 cycle by default (register loads every edge, async clear on rst_n); 0 cycles with DEMUX_1_8_COMB_OUT_EN.
// Backpressure: none; there is no enable or hold, so a new value is accepted every cycle.
module demux_1_8
    import demux_1_8_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       in,
    input  logic [SEL_W-1:0]        s,
    output logic [N_OUT*DATA_W-1:0] y
);

    logic [N_OUT-1:0]        lane_sel;
    logic [N_OUT*DATA_W-1:0] y_nxt;

    demux_1_8_dec u_dec (
        .sel (s),
        .dec (lane_sel)
    );

    // Each lane's select bit is widened to DATA_W bits and used to mask the data.
    always_comb begin
        y_nxt = '0;
        for (int k = 0; k < N_OUT; k++) begin
            y_nxt[k*DATA_W +: DATA_W] = in & {DATA_W{lane_sel[k]}};
        end
    end

`ifdef DEMUX_1_8_COMB_OUT_EN
    // clk and rst_n stay on the port list so the block drops in for either build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign y = y_nxt;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= '0;
        end else begin
            y <= y_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_demux_1_8.sv
// Self-checking bench for demux_1_8: directed reset, sweep, and latency cases, followed by randomized traffic
// checked against a shift-based reference model.
module tb_demux_1_8;

    logic       clk;
    logic       rst_n;
    logic       in;
    logic [2:0] s;
    logic [7:0] y;

    int n_chk  = 0;
    int n_pass = 0;

    demux_1_8 #(.DATA_W(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .s     (s),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    // Reference: an active data bit lands at position s; zero data or an unknown select yields nothing.
    function automatic logic [7:0] ref_y(input logic d, input logic [2:0] sel);
        logic [7:0] one;
        one = 8'd1;
        if (d !== 1'b1 || $isunknown(sel)) return 8'd0;
        return one << sel;
    endfunction

`ifndef DEMUX_1_8_COMB_OUT_EN
    logic [7:0] exp_y;

    // Samples the expectation from the inputs held across the edge, then checks the output 1 ns after that edge.
    task automatic tick(input string tag);
        logic [7:0] e;
        e = rst_n ? ref_y(in, s) : 8'd0;
        @(posedge clk);
        #1;
        exp_y = e;
        check(tag, y, exp_y);
        check({tag, "_onehot"}, 8'($countones(y) <= 1), 8'd1);
    endtask
`endif

    initial begin
`ifndef DEMUX_1_8_COMB_OUT_EN
        // Reset asserts asynchronously before the first edge, which comes at 5 ns.
        rst_n = 1'b1; in = 1'b1; s = 3'b101;
        #1 rst_n = 1'b0;
        #1 check("reset_async", y, 8'd0);
        tick("reset_hold0");
        tick("reset_hold1");

        // Release reset between edges, then sweep s across all eight lanes.
        @(negedge clk);
        rst_n = 1'b1; in = 1'b1; s = 3'd0;
        for (int k = 0; k < 8; k++) begin
            tick($sformatf("sweep_%0d", k));
            s = 3'(k + 1);
            #2 check($sformatf("sweep_hold_%0d", k), y, exp_y);
        end

        // Zero data: an unknown select and a valid select both give an all-zero output.
        in = 1'b0; s = 'x;
        tick("zero_sx");
        check("zero_sx_known", 8'(!$isunknown(y)), 8'd1);
        s = 3'b110;
        tick("zero_s6");

        // Mid-stream reset clears the output between edges; after release, the next edge reloads it.
        in = 1'b1; s = 3'b011;
        tick("mid_load");
        #2 rst_n = 1'b0;
        #1 check("mid_async_clr", y, 8'd0);
        tick("mid_held");
        #2 rst_n = 1'b1;
        #1 check("mid_release_noedge", y, 8'd0);
        tick("mid_reload");

        // Latency: s steps through every code, and the output follows exactly one edge later.
        for (int k = 0; k < 8; k++) begin
            s = 3'(k);
            #1 check($sformatf("lat_pre_%0d", k), y, exp_y);
            tick($sformatf("lat_%0d", k));
        end

        // Randomized traffic, with an occasional asynchronous reset pulse.
        for (int n = 0; n < 300; n++) begin
            in = 1'($urandom);
            s  = 3'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                #1 check("rand_async_clr", y, 8'd0);
                rst_n = 1'b1;
            end
            tick("rand");
        end
`else
        // Combinational build: the output follows the inputs with no clock, and rst_n has no effect.
        rst_n = 1'b1; in = 1'b1; s = 3'b010;
        #1 check("comb_s2", y, 8'b0000_0100);
        rst_n = 1'b0;
        #1 check("comb_rst_low", y, 8'b0000_0100);
        rst_n = 1'b1;
        #1 check("comb_rst_high", y, 8'b0000_0100);
        in = 1'b0; s = 'x;
        #1 check("comb_zero", y, 8'd0);
        for (int n = 0; n < 100; n++) begin
            in = 1'($urandom);
            s  = 3'($urandom);
            rst_n = 1'($urandom);
            #1 check("comb_rand", y, ref_y(in, s));
        end
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
